simd_mac_acc: RTL and testbench
===============================

# simd_mac_acc

Lane-wise multiply-accumulate back end that sits directly downstream of the SIMD multiplier. It sums successive 16-bit SIMD products into a 16-bit accumulator, using the same H/O/Q lane split as the multiplier: one 16-bit lane, two 8-bit lanes, or four 4-bit lanes. Products arrive on a valid/ready stream and are grouped into accumulation runs delimited by `in_last`. At the end of each run the block presents the accumulated word, beat count and per-lane overflow flags on a valid/ready result port.

## Interface
- `CNT_W`, default 8: beat-counter width; the counter saturates at all-ones.
- `clk` input 1: the single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: product beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_prod` input 16: product word from the multiplier (`mulo`).
- `in_last` input 1: beat closes the current run.
- `H` input 1: 16-bit lane mode.
- `O` input 1: 8-bit lane mode.
- `Q` input 1: 4-bit lane mode.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_acc` output 16: accumulated word.
- `out_cnt` output `CNT_W`: number of beats in the run.
- `out_ovf` output 4: per-lane overflow flags.
- `mode_err` output 1: sticky flag; the mode changed inside a run.

## Operation
- Mode decode uses priority H > O > Q. If none of H, O, Q is set, Q mode applies. This matches the multiplier.
- Lanes:
  - Q: four nibbles, [3:0] through [15:12].
  - O: two bytes.
  - H: one word.
- All lane arithmetic is unsigned. No carry crosses a lane boundary.
- States:
  - IDLE: no run is open. `in_ready`=1. An accepted beat latches the mode, sets acc = `in_prod`, sets cnt = 1, and moves to ACC. If `in_last` is set on that beat, the next state is DRAIN instead.
  - ACC: `in_ready`=1. An accepted beat computes acc = acc ⊕ `in_prod` in the latched mode and increments cnt (saturating). If `in_last` is set, the next state is DRAIN.
  - DRAIN: `in_ready`=0 and `out_valid`=1. Outputs hold steady until `out_ready`. On the handshake the block clears acc, cnt and ovf and returns to IDLE.
- Overflow flag mapping:
  - A lane carry-out sets the corresponding `out_ovf` bit.
  - Q: `out_ovf[i]` belongs to nibble lane i.
  - O: `out_ovf[0]` is the low byte and `out_ovf[1]` the high byte; bits [3:2] stay 0.
  - H: only `out_ovf[0]` is used.
  - Flags are sticky within a run.
- Mode change inside a run: if a beat's decoded mode differs from the latched mode, the beat is still accepted in the latched mode and `mode_err` is set. `mode_err` clears only on reset.
- The accumulate operator ⊕ defaults to modular add (lane wraps). See Configuration.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0, `out_acc`=0, `out_cnt`=0, `out_ovf`=0.
  - `mode_err`=0.
  - State = IDLE; latched mode = Q.
- Reset asserted mid-run or in DRAIN aborts immediately. The partial result is discarded and nothing is emitted.
- Latency: if the `in_last` beat is accepted in cycle N, `out_valid` is 1 in cycle N+1 and `out_acc` includes that beat.
- Throughput: one beat per cycle while in IDLE or ACC. No beats are accepted during DRAIN, so input and output handshakes can never coincide.
- A run has at least one beat. A single-beat run with `in_last` gives `out_acc` = `in_prod` and `out_cnt` = 1.
- `out_valid` never drops without `out_ready` having been asserted.
- `out_cnt` saturation: from beat 2^`CNT_W`−1 onward it stays at 255 (default width) and the count no longer wraps.

## Configuration
- `SIMD_ACC_SAT_EN`:
  - Defined: ⊕ is a lane-wise saturating add. On carry-out the lane clamps to all-ones (0xF, 0xFF or 0xFFFF for its width) and its ovf flag is set. The lane stays clamped for the rest of the run.
  - Undefined: ⊕ is a lane-wise wrapping add. The ovf flag is still set on carry-out.

## Structure
- Shared package `simd_pkg` holds:
  - the mode enum {MODE_Q, MODE_O, MODE_H};
  - the H/O/Q-to-mode decode function;
  - lane-mask constants 16'h000F, 16'h00FF and 16'hFFFF;
  - the state enum {IDLE, ACC, DRAIN}.
- One sub-module, `simd_lane_add`: a combinational lane-split adder taking a, b and mode, producing sum[15:0] and carry[3:0]. The saturation logic under `SIMD_ACC_SAT_EN` lives inside it.

## Test plan
- Q mode, beats 0x1234 then 0x1111 with `in_last`: `out_acc`=0x2345, `out_cnt`=2, `out_ovf`=0, and `out_valid` rises one cycle after the last beat.
- Q mode, beats 0x000F then 0x0001 with last:
  - without the macro: `out_acc`=0x0000, `out_ovf`=4'b0001;
  - with the macro: `out_acc`=0x000F, `out_ovf`=4'b0001.
- O mode, beats 0x80F0 then 0x8020 with last:
  - without the macro: `out_acc`=0x0010, `out_ovf`=4'b0011;
  - with the macro: `out_acc`=0xFFFF.
- H mode, run of 3 beats of 0x0100 with `out_ready` held low for 5 cycles: `in_ready`=0 and `out_acc`=0x0300 held steady, then on the handshake the block returns to IDLE.
- Mode change mid-run: first beat Q mode, second beat H mode with last. `mode_err`=1, the sum uses the Q lane split, and the flag survives the following run.
- Reset mid-run after 2 beats: all outputs return to their reset values, no result is emitted, and a new 1-beat run of 0x0042 gives `out_acc`=0x0042 and `out_cnt`=1.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared SIMD definitions: lane modes, H/O/Q decode, lane masks and the
// accumulator run states. Used by simd_lane_add and simd_mac_acc.
package simd_pkg;

  typedef enum logic [1:0] {
    MODE_Q = 2'd0,
    MODE_O = 2'd1,
    MODE_H = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] LANE_MASK_Q = 16'h000F;
  localparam logic [15:0] LANE_MASK_O = 16'h00FF;
  localparam logic [15:0] LANE_MASK_H = 16'hFFFF;

  // H wins over O, O over Q; nothing set falls back to Q like the multiplier.
  function automatic mode_t decode_mode(input logic h, input logic o, input logic q);
    mode_t m;
    if (h) begin
      m = MODE_H;
    end else if (o) begin
      m = MODE_O;
    end else begin
      m = MODE_Q;
    end
    return m;
  endfunction

endpackage

// File: rtl/simd_lane_add.sv
// Combinational lane-split adder (4x4, 2x8 or 1x16 bit, unsigned, no carry
// across lanes). Define SIMD_ACC_SAT_EN to clamp a carrying lane to all-ones.
module simd_lane_add
  import simd_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  mode_t       mode,
  output logic [15:0] sum,
  output logic [3:0]  carry
);

  logic [4:0]  q_raw_s [4];
  logic [8:0]  o_raw_s [2];
  logic [16:0] h_raw_s;
  logic [15:0] q_sum_s;
  logic [15:0] o_sum_s;
  logic [15:0] h_sum_s;
  logic [3:0]  q_c_s;
  logic [1:0]  o_c_s;
  logic        h_c_s;

  for (genvar i = 0; i < 4; i++) begin : g_q
    assign q_raw_s[i] = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
    assign q_c_s[i]   = q_raw_s[i][4];
`ifdef SIMD_ACC_SAT_EN
    assign q_sum_s[4*i +: 4] = q_raw_s[i][4] ? LANE_MASK_Q[3:0] : q_raw_s[i][3:0];
`else
    assign q_sum_s[4*i +: 4] = q_raw_s[i][3:0];
`endif
  end

  for (genvar j = 0; j < 2; j++) begin : g_o
    assign o_raw_s[j] = {1'b0, a[8*j +: 8]} + {1'b0, b[8*j +: 8]};
    assign o_c_s[j]   = o_raw_s[j][8];
`ifdef SIMD_ACC_SAT_EN
    assign o_sum_s[8*j +: 8] = o_raw_s[j][8] ? LANE_MASK_O[7:0] : o_raw_s[j][7:0];
`else
    assign o_sum_s[8*j +: 8] = o_raw_s[j][7:0];
`endif
  end

  assign h_raw_s = {1'b0, a} + {1'b0, b};
  assign h_c_s   = h_raw_s[16];
`ifdef SIMD_ACC_SAT_EN
  assign h_sum_s = h_raw_s[16] ? LANE_MASK_H : h_raw_s[15:0];
`else
  assign h_sum_s = h_raw_s[15:0];
`endif

  // Select the lane split for the requested mode.
  always_comb begin
    sum   = q_sum_s;
    carry = q_c_s;
    case (mode)
      MODE_Q: begin
        sum   = q_sum_s;
        carry = q_c_s;
      end
      MODE_O: begin
        sum   = o_sum_s;
        carry = {2'b00, o_c_s};
      end
      MODE_H: begin
        sum   = h_sum_s;
        carry = {3'b000, h_c_s};
      end
      default: begin
        sum   = q_sum_s;
        carry = q_c_s;
      end
    endcase
  end

endmodule

// File: rtl/simd_mac_acc.sv
// Lane-wise multiply-accumulate back end: sums SIMD product beats per run
// and presents acc/count/overflow on a valid/ready port. Option: SIMD_ACC_SAT_EN.
module simd_mac_acc
  import simd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  input  logic             H,
  input  logic             O,
  input  logic             Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic [3:0]       out_ovf,
  output logic             mode_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  mode_t            mode_r;
  mode_t            beat_mode_s;
  logic [15:0]      acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       ovf_r;
  logic             mode_err_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic [15:0]      sum_s;
  logic [3:0]       carry_s;

  assign beat_mode_s = decode_mode(H, O, Q);
  assign accept_s    = in_valid & in_ready_r;

  simd_lane_add u_lane_add (
    .a     (acc_r),
    .b     (in_prod),
    .mode  (mode_r),
    .sum   (sum_s),
    .carry (carry_s)
  );

  // Run state machine; every output comes straight from a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mode_r      <= MODE_Q;
      acc_r       <= 16'h0000;
      cnt_r       <= '0;
      ovf_r       <= 4'b0000;
      mode_err_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mode_r <= beat_mode_s;
            acc_r  <= in_prod;
            cnt_r  <= CNT_ONE;
            ovf_r  <= 4'b0000;
            if (in_last) begin
              state_r     <= DRAIN;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ACC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACC: begin
          if (accept_s) begin
            // A beat in a different mode is still summed in the latched split.
            acc_r <= sum_s;
            ovf_r <= ovf_r | carry_s;
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              cnt_r <= cnt_r;
            end
            if (beat_mode_s != mode_r) begin
              mode_err_r <= 1'b1;
            end else begin
              mode_err_r <= mode_err_r;
            end
            if (in_last) begin
              state_r     <= DRAIN;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ACC;
            end
          end else begin
            state_r <= ACC;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state_r     <= IDLE;
            acc_r       <= 16'h0000;
            cnt_r       <= '0;
            ovf_r       <= 4'b0000;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= 16'h0000;
          cnt_r       <= '0;
          ovf_r       <= 4'b0000;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_acc   = acc_r;
  assign out_cnt   = cnt_r;
  assign out_ovf   = ovf_r;
  assign mode_err  = mode_err_r;

endmodule

// File: tb/tb_simd_mac_acc.sv
// Self-checking bench for simd_mac_acc: directed vector table, random runs
// against a lane-arithmetic model, and hand-written multi-cycle sequences.
module tb_simd_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_prod = 16'h0000;
  logic        in_last = 1'b0;
  logic        H = 1'b0;
  logic        O = 1'b0;
  logic        Q = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_acc;
  logic [7:0]  out_cnt;
  logic [3:0]  out_ovf;
  logic        mode_err;

  int checks = 0;
  int errors = 0;

`ifdef SIMD_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  simd_mac_acc #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .H         (H),
    .O         (O),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf),
    .mode_err  (mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    int          mode;
    logic [15:0] exp_acc;
    logic [3:0]  exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // mode: 0 = Q, 1 = O, 2 = H; lower-priority bits are randomised to exercise decode
  task automatic set_mode(input int m);
    case (m)
      2: begin H = 1'b1; O = 1'($urandom_range(1)); Q = 1'($urandom_range(1)); end
      1: begin H = 1'b0; O = 1'b1; Q = 1'($urandom_range(1)); end
      default: begin H = 1'b0; O = 1'b0; Q = 1'($urandom_range(1)); end
    endcase
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the beat.
  task automatic beat(input logic [15:0] p, input logic last, input int m);
    set_mode(m);
    in_prod  = p;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [15:0] e_acc,
                            input logic [7:0] e_cnt, input logic [3:0] e_ovf, input int delay);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_acc"}, 32'(out_acc), 32'(e_acc));
    chk({name, "_cnt"}, 32'(out_cnt), 32'(e_cnt));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(e_ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reference: per-lane integer add, carry when the lane sum exceeds its mask.
  task automatic model_add(input logic [15:0] a, input logic [15:0] b, input int m,
                           input logic [3:0] ovf_in, output logic [15:0] res,
                           output logic [3:0] ovf_out);
    int w;
    int mask;
    int s;
    int r;
    w = (m == 2) ? 16 : (m == 1) ? 8 : 4;
    mask = (1 << w) - 1;
    r = 0;
    ovf_out = ovf_in;
    for (int i = 0; i < 16 / w; i++) begin
      s = ((int'(a) >> (i * w)) & mask) + ((int'(b) >> (i * w)) & mask);
      if (s > mask) begin
        ovf_out[i] = 1'b1;
        s = SAT ? mask : (s & mask);
      end
      r = r | (s << (i * w));
    end
    res = 16'(r);
  endtask

  vec_t vecs[7];

  initial begin
    logic [15:0] m_acc;
    logic [3:0]  m_ovf;
    logic [15:0] p;
    int          len;
    int          md;
    int          cnt;

    vecs[0] = '{16'h1234, 16'h1111, 0, 16'h2345, 4'b0000};
    vecs[1] = '{16'h000F, 16'h0001, 0, SAT ? 16'h000F : 16'h0000, 4'b0001};
    vecs[2] = '{16'h80F0, 16'h8020, 1, SAT ? 16'hFFFF : 16'h0010, 4'b0011};
    vecs[3] = '{16'h0102, 16'h0304, 1, 16'h0406, 4'b0000};
    vecs[4] = '{16'hFFFF, 16'h0002, 2, SAT ? 16'hFFFF : 16'h0001, 4'b0001};
    vecs[5] = '{16'h8888, 16'h8888, 0, SAT ? 16'hFFFF : 16'h0000, 4'b1111};
    vecs[6] = '{16'h7F00, 16'h0100, 2, 16'h8000, 4'b0000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(out_acc), 32'd0);
    chk("rst_cnt", 32'(out_cnt), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_mode_err", 32'(mode_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      beat(vecs[v].p0, 1'b0, vecs[v].mode);
      chk("vec_no_early_valid", 32'(out_valid), 32'd0);
      beat(vecs[v].p1, 1'b1, vecs[v].mode);
      chk("vec_latency", 32'(out_valid), 32'd1);
      chk("vec_in_ready_low", 32'(in_ready), 32'd0);
      get_result($sformatf("vec%0d", v), vecs[v].exp_acc, 8'd2, vecs[v].exp_ovf, 0);
    end

    // Single-beat run
    beat(16'hBEEF, 1'b1, 1);
    get_result("single", 16'hBEEF, 8'd1, 4'b0000, 0);

    for (int r = 0; r < 40; r++) begin
      md  = $urandom_range(2);
      len = $urandom_range(1, 6);
      m_ovf = 4'b0000;
      m_acc = 16'h0000;
      for (int b = 0; b < len; b++) begin
        p = 16'($urandom);
        if (b == 0) m_acc = p;
        else model_add(m_acc, p, md, m_ovf, m_acc, m_ovf);
        beat(p, b == len - 1, md);
        if ($urandom_range(3) == 0 && b != len - 1) begin
          @(posedge clk); #1;
        end
      end
      get_result($sformatf("rand%0d", r), m_acc, 8'(len), m_ovf, $urandom_range(2));
    end
    chk("mode_err_clean", 32'(mode_err), 32'd0);

    // Count saturation: 300 beats of 1 in H mode
    for (int b = 0; b < 300; b++) beat(16'h0001, b == 299, 2);
    get_result("cnt_sat", 16'd300, 8'd255, 4'b0000, 0);

    // Held result under back-pressure
    beat(16'h0100, 1'b0, 2);
    beat(16'h0100, 1'b0, 2);
    beat(16'h0100, 1'b1, 2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_acc", 32'(out_acc), 32'h0300);
      chk("stall_cnt", 32'(out_cnt), 32'd3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_idle_ready", 32'(in_ready), 32'd1);
    chk("stall_idle_valid", 32'(out_valid), 32'd0);
    chk("stall_idle_acc", 32'(out_acc), 32'd0);

    // Mode change inside a run: summed in the first beat's Q split
    beat(16'h000F, 1'b0, 0);
    beat(16'h0001, 1'b1, 2);
    chk("modechg_err", 32'(mode_err), 32'd1);
    get_result("modechg", SAT ? 16'h000F : 16'h0000, 8'd2, 4'b0001, 0);
    beat(16'h0011, 1'b1, 1);
    get_result("modechg_next", 16'h0011, 8'd1, 4'b0000, 0);
    chk("modechg_sticky", 32'(mode_err), 32'd1);

    // Reset in the middle of a run
    beat(16'h1111, 1'b0, 0);
    beat(16'h2222, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_acc", 32'(out_acc), 32'd0);
    chk("mrst_cnt", 32'(out_cnt), 32'd0);
    chk("mrst_ovf", 32'(out_ovf), 32'd0);
    chk("mrst_mode_err", 32'(mode_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mrst_no_emit", 32'(out_valid), 32'd0);
    beat(16'h0042, 1'b1, 0);
    chk("mrst_latency", 32'(out_valid), 32'd1);
    get_result("mrst_new", 16'h0042, 8'd1, 4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
